// File: rtl/dii_depacketizer.sv
// DII packet terminator: collects one packet into parallel header and
// payload fields and presents it through a single-entry valid/ready stage.
module dii_depacketizer #(
  parameter  int WIDTH       = 16,
  parameter  int MAX_PAYLOAD = 8,
  localparam int LW          = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_dest,
  output logic [WIDTH-1:0]             out_src,
  output logic [WIDTH-1:0]             out_flags,
  output logic [MAX_PAYLOAD*WIDTH-1:0] out_payload,
  output logic [LW-1:0]                out_len,
  output logic                         out_overflow,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         err_short
);

  typedef enum logic [2:0] {
    S_DEST,
    S_SRC,
    S_FLAGS,
    S_PAY,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pay_q [MAX_PAYLOAD];
  logic             beat;
  logic             full;

  assign beat = in_valid & in_ready;
  assign full = (out_len == LW'(MAX_PAYLOAD));

  // Pack the slot array onto the flat payload bus, slot k at [k*WIDTH +: WIDTH].
  for (genvar k = 0; k < MAX_PAYLOAD; k++) begin : g_pack
    assign out_payload[k*WIDTH +: WIDTH] = pay_q[k];
  end

  // Packet parser and output register stage; out_len doubles as the
  // payload write pointer and saturates once every slot is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_DEST;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      err_short    <= 1'b0;
      out_dest     <= '0;
      out_src      <= '0;
      out_flags    <= '0;
      out_len      <= '0;
      out_overflow <= 1'b0;
      for (int k = 0; k < MAX_PAYLOAD; k++) begin
        pay_q[k] <= '0;
      end
    end else begin
      err_short <= 1'b0;
      unique case (state)
        S_DEST: begin
          if (beat) begin
            out_dest <= in_data;
            if (in_last) begin
              err_short <= 1'b1;
            end else begin
              state <= S_SRC;
            end
          end
        end
        S_SRC: begin
          if (beat) begin
            out_src <= in_data;
            if (in_last) begin
              err_short <= 1'b1;
              state     <= S_DEST;
            end else begin
              state <= S_FLAGS;
            end
          end
        end
        S_FLAGS: begin
          if (beat) begin
            out_flags <= in_data;
            if (in_last) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= S_PAY;
            end
          end
        end
        S_PAY: begin
          if (beat) begin
            if (full) begin
              out_overflow <= 1'b1;
            end else begin
              for (int k = 0; k < MAX_PAYLOAD; k++) begin
                if (out_len == LW'(k)) begin
                  pay_q[k] <= in_data;
                end
              end
              out_len <= out_len + LW'(1);
            end
            if (in_last) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state        <= S_DEST;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_len      <= '0;
            out_overflow <= 1'b0;
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              pay_q[k] <= '0;
            end
          end
        end
        default: begin
          state    <= S_DEST;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
